// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for the uart_tx peripheral.
// The core side drives the request; the transmitter drives line and status.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_tx;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start,
    output i_data,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_data,
    output o_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Line, busy and done are all registered so o_tx only moves on bit boundaries.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_DATA  = 2'd2;
  localparam logic [1:0] STATE_STOP  = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_s;
  logic                  tx_r;
  logic                  tx_s;
  logic                  busy_r;
  logic                  busy_s;
  logic                  done_r;
  logic                  done_s;
  logic                  bit_end_s;

  // Next-state and next-output computation; outputs are precomputed so the registers drive the pins.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    bit_end_s = (cnt_r == CNT_LAST);

    case (state_r)
      STATE_IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (bus.i_start) begin
          shift_s = bus.i_data;
          cnt_s   = CNT_ZERO;
          idx_s   = IDX_ZERO;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
          state_s = STATE_START;
        end else begin
          state_s = STATE_IDLE;
        end
      end

      STATE_START: begin
        if (bit_end_s) begin
          cnt_s   = CNT_ZERO;
          idx_s   = IDX_ZERO;
          tx_s    = shift_r[0];
          state_s = STATE_DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      STATE_DATA: begin
        if (bit_end_s) begin
          cnt_s   = CNT_ZERO;
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            tx_s    = 1'b1;
            state_s = STATE_STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
            // The next data bit is whatever lands in bit 0 after this shift.
            tx_s  = shift_s[0];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      STATE_STOP: begin
        if (bit_end_s) begin
          cnt_s   = CNT_ZERO;
          tx_s    = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = STATE_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        state_s = STATE_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous abort to an idle-high line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= STATE_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_WIDTH{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.o_tx   = tx_r;
  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table-driven frames at 4 clocks/bit plus
// busy-ignore, back-to-back, held-start, mid-frame reset and baud sweeps.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) bus4 ();
  uart_tx_if #(.DATA_WIDTH(8)) bus2 ();
  uart_tx_if #(.DATA_WIDTH(8)) bus434 ();

  uart_tx #(.CLKS_PER_BIT(4),   .DATA_WIDTH(8)) dut4   (.i_clk(clk), .i_rst(rst), .bus(bus4.slave));
  uart_tx #(.CLKS_PER_BIT(2),   .DATA_WIDTH(8)) dut2   (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));
  uart_tx #(.CLKS_PER_BIT(434), .DATA_WIDTH(8)) dut434 (.i_clk(clk), .i_rst(rst), .bus(bus434.slave));

  int checks   = 0;
  int failures = 0;

  // Sweep instances share one stimulus/observation path selected by sel.
  int         sel = 0;
  logic       sw_start = 1'b0;
  logic [7:0] sw_data  = 8'h00;
  logic       sw_tx;
  logic       sw_done;

  assign bus2.i_start   = (sel == 0) ? sw_start : 1'b0;
  assign bus2.i_data    = sw_data;
  assign bus434.i_start = (sel == 1) ? sw_start : 1'b0;
  assign bus434.i_data  = sw_data;

  always_comb begin
    sw_tx   = (sel == 0) ? bus2.o_tx   : bus434.o_tx;
    sw_done = (sel == 0) ? bus2.o_done : bus434.o_done;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] slots;  // bit 9 = start slot ... bit 0 = stop slot
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic accept4(input logic [7:0] d);
    @(negedge clk);
    bus4.i_start = 1'b1;
    bus4.i_data  = d;
    @(negedge clk);
    bus4.i_start = 1'b0;
    bus4.i_data  = ~d;
  endtask

  // Entered in cycle N+1 of a frame; checks every cycle through the o_done cycle.
  task automatic verify4(input string nm, input logic [9:0] slots, input int poke,
                         input logic [7:0] poke_d, input bit b2b, input logic [7:0] next_d);
    for (int k = 1; k <= 40; k++) begin
      check($sformatf("%s_c%0d", nm, k), {bus4.o_tx, bus4.o_busy, bus4.o_done},
            {slots[9 - (k - 1) / 4], 2'b10});
      if (k == poke) begin
        bus4.i_start = 1'b1;
        bus4.i_data  = poke_d;
      end else if (k == poke + 1) begin
        bus4.i_start = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, "_done"}, {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b101);
    if (b2b) begin
      bus4.i_start = 1'b1;
      bus4.i_data  = next_d;
      @(negedge clk);
      bus4.i_start = 1'b0;
      bus4.i_data  = ~next_d;
    end else begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check({nm, "_idle"}, {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b100);
      end
    end
  endtask

  // Bench receiver: mid-bit sampling of each slot, frame length from acceptance to o_done.
  task automatic sweep_frame(input int cpb, input logic [7:0] d);
    logic [9:0] got;
    int         len;
    bit         seen;
    @(negedge clk);
    sw_start = 1'b1;
    sw_data  = d;
    @(negedge clk);
    sw_start = 1'b0;
    sw_data  = ~d;
    got  = 10'h3ff;
    len  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 12 * cpb && !seen; c++) begin
      for (int s = 0; s < 10; s++) begin
        if (c == s * cpb + cpb / 2 + 1) got[s] = sw_tx;
      end
      if (sw_done) begin
        seen = 1'b1;
        len  = c - 1;
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("sweep%0d_byte", cpb), {24'h0, got[8:1]}, {24'h0, d});
    check($sformatf("sweep%0d_start_stop", cpb), {30'h0, got[9], got[0]}, 32'h2);
    check($sformatf("sweep%0d_len", cpb), len, 10 * cpb);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, slots: 10'b0101001011};
    vecs[1] = '{data: 8'h00, slots: 10'b0000000001};
    vecs[2] = '{data: 8'hFF, slots: 10'b0111111111};
    vecs[3] = '{data: 8'h3C, slots: 10'b0001111001};
    vecs[4] = '{data: 8'h81, slots: 10'b0100000011};

    bus4.i_start = 1'b0;
    bus4.i_data  = 8'h00;

    // Asynchronous reset, sampled between clock edges.
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_dut4",   {bus4.o_tx,   bus4.o_busy,   bus4.o_done},   3'b100);
    check("reset_dut2",   {bus2.o_tx,   bus2.o_busy,   bus2.o_done},   3'b100);
    check("reset_dut434", {bus434.o_tx, bus434.o_busy, bus434.o_done}, 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_after_reset", {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b100);
    end

    for (int i = 0; i < 5; i++) begin
      accept4(vecs[i].data);
      verify4($sformatf("vec%0d", i), vecs[i].slots, -10, 8'h00, 1'b0, 8'h00);
    end

    accept4(8'h0F);
    verify4("busy_ignore", 10'b0111100001, 10, 8'hFF, 1'b0, 8'h00);

    accept4(8'h55);
    verify4("b2b_first", 10'b0101010101, -10, 8'h00, 1'b1, 8'h81);
    verify4("b2b_second", 10'b0100000011, -10, 8'h00, 1'b0, 8'h00);

    // i_start held high across a whole frame: re-accepted in the o_done cycle.
    @(negedge clk);
    bus4.i_start = 1'b1;
    bus4.i_data  = 8'h81;
    @(negedge clk);
    bus4.i_data  = 8'h00;
    verify4("held_first", 10'b0100000011, -10, 8'h00, 1'b1, 8'hA5);
    verify4("held_second", 10'b0101001011, -10, 8'h00, 1'b0, 8'h00);

    // Abort inside data bit 3 (slot 4, cycles 17..20) of 0xC3.
    accept4(8'hC3);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("abort_pre_c%0d", k), {bus4.o_tx, bus4.o_busy, bus4.o_done},
            {(k <= 4) ? 1'b0 : ((k <= 12) ? 1'b1 : 1'b0), 2'b10});
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("abort_immediate", {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b100);
    repeat (2) @(negedge clk);
    check("abort_held", {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b100);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_idle", {bus4.o_tx, bus4.o_busy, bus4.o_done}, 3'b100);
    end
    accept4(8'h3C);
    verify4("after_abort", 10'b0001111001, -10, 8'h00, 1'b0, 8'h00);

    sel = 0;
    for (int i = 0; i < 50; i++) sweep_frame(2, 8'($urandom_range(0, 255)));
    sel = 1;
    for (int i = 0; i < 4; i++) sweep_frame(434, 8'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
